// File: rtl/irq_pending_arbiter_if.sv
// rtl/irq_pending_arbiter_if.sv - grant handshake between the arbiter and its consumer
interface irq_pending_arbiter_if #(
   parameter int IDW = 3
);
   logic           grant_valid;
   logic [IDW-1:0] grant_id;
   logic           grant_ready;

   modport master (
      output grant_valid,
      output grant_id,
      input  grant_ready
   );

   modport slave (
      input  grant_valid,
      input  grant_id,
      output grant_ready
   );
endinterface

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - request capture, pending register and held MSB-first grant
module irq_pending_arbiter #(
   parameter int N   = 8,
   parameter int IDW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_in,
   input  logic [N-1:0]         mask,
   input  logic                 edge_mode,
   irq_pending_arbiter_if.master gnt,
   output logic [N-1:0]         pending,
   output logic                 overflow
);
   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state;
   logic [N-1:0]   req_q;
   logic           gv;
   logic [IDW-1:0] gid;
   logic [N-1:0]   set_vec;
   logic [N-1:0]   clear_vec;
   logic [N-1:0]   eligible;
   logic [IDW-1:0] win_id;
   logic           fire;

   assign gnt.grant_valid = gv;
   assign gnt.grant_id    = gid;

   assign fire      = gv & gnt.grant_ready;
   assign set_vec   = edge_mode ? (req_in & ~req_q) : req_in;
   assign clear_vec = fire ? (N'(1) << gid) : '0;
   assign eligible  = pending & mask;

   // Ascending scan so the highest eligible index is the last one written.
   always_comb begin
      win_id = '0;
      for (int i = 0; i < N; i++) begin
         if (eligible[i]) win_id = IDW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_q    <= '0;
         pending  <= '0;
         gv       <= 1'b0;
         gid      <= '0;
         overflow <= 1'b0;
      end else begin
         req_q    <= req_in;
         pending  <= (pending & ~clear_vec) | set_vec;
         overflow <= edge_mode & (|(set_vec & pending & ~clear_vec));
         case (state)
            IDLE: begin
               if (|eligible) begin
                  gid   <= win_id;
                  gv    <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               // Grant is held unchanged until accepted; no preemption.
               if (fire) begin
                  gv    <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               gv    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - randomized and directed checks against a behavioural model
module tb_irq_pending_arbiter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req_in = '0;
   logic [7:0] mask = '0;
   logic       edge_mode = 1'b1;
   logic [7:0] pending;
   logic       overflow;

   irq_pending_arbiter_if #(.IDW(3)) gif();

   irq_pending_arbiter #(.N(8), .IDW(3)) dut (
      .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
      .edge_mode(edge_mode), .gnt(gif.master),
      .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   bit [7:0] m_pend;
   bit [7:0] m_reqq;
   bit       m_gv;
   int       m_gid;
   bit       m_ovf;
   int       accepted[$];

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_reqq = 0; m_gv = 0; m_gid = 0; m_ovf = 0;
   endtask

   // Applies the capture / select / handshake rules to one clock edge.
   task automatic model_step(input bit [7:0] req, input bit [7:0] msk, input bit em, input bit rdy);
      bit [7:0] s, c, elig;
      bit       fire;
      s    = em ? (req & ~m_reqq) : req;
      fire = m_gv && rdy;
      c    = fire ? 8'(1 << m_gid) : 8'h00;
      m_ovf = em && ((s & m_pend & ~c) != 0);
      elig = m_pend & msk;
      if (!m_gv) begin
         if (elig != 0) begin
            for (int b = 7; b >= 0; b--) begin
               if (elig[b]) begin
                  m_gid = b;
                  break;
               end
            end
            m_gv = 1;
         end
      end else if (fire) begin
         m_gv = 0;
      end
      m_pend = (m_pend & ~c) | s;
      m_reqq = req;
   endtask

   task automatic cyc(input bit [7:0] req, input bit [7:0] msk, input bit em, input bit rdy);
      req_in = req; mask = msk; edge_mode = em; gif.grant_ready = rdy;
      if (gif.grant_valid && rdy) accepted.push_back(int'(gif.grant_id));
      model_step(req, msk, em, rdy);
      @(posedge clk);
      #1;
      check("pending", int'(pending), int'(m_pend));
      check("grant_valid", int'(gif.grant_valid), int'(m_gv));
      check("overflow", int'(overflow), int'(m_ovf));
      if (m_gv) check("grant_id", int'(gif.grant_id), m_gid);
   endtask

   initial begin
      int cnt;
      gif.grant_ready = 1'b0;
      model_reset();
      #1;
      check("rst_valid", int'(gif.grant_valid), 0);
      check("rst_pending", int'(pending), 0);
      check("rst_overflow", int'(overflow), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic edge capture
      cyc(8'h01, 8'hFF, 1, 0);
      check("s1_pending", int'(pending), 8'h01);
      cyc(8'h00, 8'hFF, 1, 0);
      check("s1_valid", int'(gif.grant_valid), 1);
      check("s1_id", int'(gif.grant_id), 0);
      cyc(8'h00, 8'hFF, 1, 1);
      check("s1_cleared", int'(pending), 0);
      check("s1_idle", int'(gif.grant_valid), 0);

      // Priority order 7, 5, 0
      accepted.delete();
      cyc(8'hA1, 8'hFF, 1, 1);
      repeat (8) cyc(8'h00, 8'hFF, 1, 1);
      check("s2_count", accepted.size(), 3);
      if (accepted.size() == 3) begin
         check("s2_first", accepted[0], 7);
         check("s2_second", accepted[1], 5);
         check("s2_third", accepted[2], 0);
      end
      check("s2_pending", int'(pending), 0);

      // Backpressure without preemption
      cyc(8'h08, 8'hFF, 1, 0);
      cyc(8'h00, 8'hFF, 1, 0);
      cyc(8'h40, 8'hFF, 1, 0);
      for (int i = 0; i < 5; i++) begin
         cyc(8'h00, 8'hFF, 1, 0);
         check("s3_hold_valid", int'(gif.grant_valid), 1);
         check("s3_hold_id", int'(gif.grant_id), 3);
      end
      cyc(8'h00, 8'hFF, 1, 1);
      cyc(8'h00, 8'hFF, 1, 0);
      check("s3_next_id", int'(gif.grant_id), 6);
      cyc(8'h00, 8'hFF, 1, 1);

      // Masking
      cyc(8'h11, 8'h0F, 1, 1);
      cyc(8'h00, 8'h0F, 1, 1);
      check("s4_id0", int'(gif.grant_id), 0);
      repeat (3) cyc(8'h00, 8'h0F, 1, 1);
      check("s4_no_grant", int'(gif.grant_valid), 0);
      check("s4_pending", int'(pending), 8'h10);
      cyc(8'h00, 8'hFF, 1, 0);
      check("s4_id4", int'(gif.grant_id), 4);
      cyc(8'h00, 8'hFF, 1, 1);

      // Overflow, then set-wins on acceptance
      cyc(8'h04, 8'h00, 1, 0);
      cyc(8'h00, 8'h00, 1, 0);
      cyc(8'h04, 8'h00, 1, 0);
      check("s5_overflow", int'(overflow), 1);
      check("s5_pending", int'(pending), 8'h04);
      cyc(8'h00, 8'h00, 1, 0);
      check("s5_overflow_pulse", int'(overflow), 0);
      cyc(8'h00, 8'hFF, 1, 0);
      cyc(8'h04, 8'hFF, 1, 1);
      check("s5_setwins", int'(pending), 8'h04);
      check("s5_no_overflow", int'(overflow), 0);
      cyc(8'h00, 8'hFF, 1, 1);
      cyc(8'h00, 8'hFF, 1, 1);

      // Level mode repeated grants
      accepted.delete();
      repeat (8) cyc(8'h04, 8'hFF, 0, 1);
      check("s6_grants", accepted.size(), 3);
      foreach (accepted[i]) check("s6_id", accepted[i], 2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit [7:0] r, m;
         r = 8'($urandom) & 8'($urandom);
         m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         cyc(r, m, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset during a grant
      cnt = 0;
      while (!gif.grant_valid && cnt < 20) begin
         cyc(8'h04, 8'hFF, 0, 0);
         cnt++;
      end
      check("s7_grant_up", int'(gif.grant_valid), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("s7_async_valid", int'(gif.grant_valid), 0);
      check("s7_async_pending", int'(pending), 0);
      check("s7_async_overflow", int'(overflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
